// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Fetch FSM states and the fetch-queue entry layout.
package ifu_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small fetch queue: push/pop/flush with occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  ifu_entry_t    i_data,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic          o_valid,
   output ifu_entry_t    o_head,
   output logic [CW-1:0] o_count
);

   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   ifu_entry_t    r_mem [DEPTH];

   // pointers and occupancy; a flush discards everything queued
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push)
            r_wp <= r_wp + 1'b1;
         if (i_pop)
            r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end
   end

   // entry storage; contents are only observed while counted valid
   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush)
         r_mem[r_wp] <= i_data;
   end

   assign o_valid = (r_cnt != '0);
   assign o_head  = r_mem[r_rp];
   assign o_count = r_cnt;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, imem req/ack, fetch queue.
// Slots are reserved at request time so the queue cannot overflow.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = ifu_pkg::RESET_PC,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4
);

   import ifu_pkg::*;

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_fetch_pc;
   logic [31:0]  w_fetch_pc_nxt;
   logic [31:0]  r_addr;
   logic [31:0]  w_addr_nxt;
   logic [31:0]  w_rpc;
   logic [31:0]  w_pc_inc;
   logic         w_push;
   logic         w_pop;
   logic         w_fifo_valid;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_free;
   ifu_entry_t   w_head;
   ifu_entry_t   w_push_data;

   assign w_rpc       = redirect_pc & ~32'h3;
   assign w_pc_inc    = r_fetch_pc + 32'd4;
   assign w_pop       = w_fifo_valid & id_ready;
   assign w_free      = CW'(QDEPTH) - w_count + CW'(w_pop);
   assign w_push_data = {imem_rdata, r_fetch_pc};

   ifu_fifo #(
      .DEPTH (QDEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .o_valid (w_fifo_valid),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // next-state, next fetch PC and request address; redirect wins
   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_addr_nxt     = r_addr;
      w_push         = 1'b0;
      if (redirect)
         w_fetch_pc_nxt = w_rpc;
      unique case (r_state)
         S_IDLE: begin
            if (redirect) begin
               w_state_nxt = S_WAIT;
               w_addr_nxt  = w_rpc;
            end else if (w_free != '0) begin
               w_state_nxt = S_WAIT;
               w_addr_nxt  = r_fetch_pc;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               if (imem_ack)
                  w_addr_nxt = w_rpc;
               else
                  w_state_nxt = S_DROP;
            end else if (imem_ack) begin
               w_push         = 1'b1;
               w_fetch_pc_nxt = w_pc_inc;
               w_addr_nxt     = w_pc_inc;
               w_state_nxt    = (w_free > CW'(1)) ? S_WAIT : S_IDLE;
            end
         end
         S_DROP: begin
            if (imem_ack) begin
               w_state_nxt = S_WAIT;
               w_addr_nxt  = w_fetch_pc_nxt;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // state, fetch PC and request address registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_addr     <= RESET_PC;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_addr     <= w_addr_nxt;
      end
   end

   assign imem_req  = (r_state != S_IDLE);
   assign imem_addr = r_addr;
   assign id_valid  = w_fifo_valid;
   assign id_instr  = w_fifo_valid ? w_head.instr : 32'd0;
   assign id_pc     = w_fifo_valid ? w_head.pc : 32'd0;
   assign id_pc4    = w_fifo_valid ? (w_head.pc + 32'd4) : 32'd0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: random memory latency,
// decode back-pressure and redirects against a program-order model.
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam int          QD     = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int ack_pct = 0;
   int rdy_pct = 0;
   int rdir_pct = 0;
   bit force_rdir = 0;
   logic [31:0] force_tgt = '0;

   ifu_fetch #(
      .RESET_PC (RST_PC),
      .QDEPTH   (QD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pc4      (id_pc4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // memory, redirect and decode stimulus plus fetch-order model
   initial begin : drv
      bit outst = 0;
      bit taint = 0;
      bit ack;
      bit rd;
      logic [31:0] lat = '0;
      logic [31:0] mfpc = RST_PC;
      logic [31:0] tgt;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            outst = 0;
            taint = 0;
            mfpc = RST_PC;
            exp_q.delete();
            imem_ack = 1'b0;
            redirect = 1'b0;
            id_ready = 1'b0;
            continue;
         end
         if (outst) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", imem_addr, lat);
         end else if (imem_req) begin
            chk("req_addr", imem_addr, mfpc);
            outst = 1;
            lat = imem_addr;
         end
         ack = outst && ($urandom_range(99) < ack_pct);
         rd = force_rdir || ($urandom_range(99) < rdir_pct);
         tgt = force_rdir ? force_tgt : $urandom();
         force_rdir = 0;
         imem_ack = ack;
         imem_rdata = (ack && !taint && !rd) ? mem_word(lat) : $urandom();
         redirect = rd;
         redirect_pc = tgt;
         id_ready = ($urandom_range(99) < rdy_pct);
         if (ack) begin
            if (!taint && !rd) begin
               exp_q.push_back('{mem_word(mfpc), mfpc, cyc});
               mfpc = mfpc + 32'd4;
            end
            outst = 0;
            taint = 0;
         end
         if (rd) begin
            mfpc = tgt & ~32'h3;
            if (outst)
               taint = 1;
         end
      end
   end

   // decode-side monitor: pops expected beats and checks hold/latency
   initial begin : mon
      bit pstall = 0;
      bit pflush = 1;
      logic [31:0] pinstr = '0;
      logic [31:0] ppc = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            pstall = 0;
            continue;
         end
         if (pstall && !pflush) begin
            chk("hold_valid", 32'(id_valid), 32'd1);
            chk("hold_instr", id_instr, pinstr);
            chk("hold_pc", id_pc, ppc);
         end
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc)
            chk("latency_valid", 32'(id_valid), 32'd1);
         if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_beat: got pc %h, none expected",
                        id_pc);
            end else begin
               e = exp_q.pop_front();
               chk("id_pc", id_pc, e.pc);
               chk("id_instr", id_instr, e.instr);
               chk("id_pc4", id_pc4, e.pc + 32'd4);
            end
         end
         if (redirect)
            exp_q.delete();
         pstall = id_valid && !id_ready;
         pflush = redirect;
         pinstr = id_instr;
         ppc = id_pc;
      end
   end

   initial begin
      run(2);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_instr", id_instr, 32'd0);
      chk("rst_pc", id_pc, 32'd0);
      chk("rst_pc4", id_pc4, 32'd0);
      rst = 1'b0;

      ack_pct = 100; rdy_pct = 100; rdir_pct = 0;
      run(20);

      rdy_pct = 0;
      run(10);
      chk("full_req_drop", 32'(imem_req), 32'd0);
      chk("full_valid", 32'(id_valid), 32'd1);
      chk("full_depth", 32'(exp_q.size()), 32'(QD));
      rdy_pct = 100;
      run(10);

      ack_pct = 0;
      run(4);
      ack_pct = 100;
      run(4);

      ack_pct = 0;
      run(1);
      force_tgt = 32'h0000_3043;
      force_rdir = 1;
      run(4);
      chk("drop_req", 32'(imem_req), 32'd1);
      chk("drop_empty", 32'(id_valid), 32'd0);
      ack_pct = 100;
      run(8);

      force_tgt = 32'h0000_4000;
      force_rdir = 1;
      run(6);

      ack_pct = 60; rdy_pct = 60; rdir_pct = 4;
      run(3000);

      ack_pct = 100; rdy_pct = 100; rdir_pct = 0;
      run(4);
      force_tgt = 32'hFFFF_FFF8;
      force_rdir = 1;
      run(8);

      ack_pct = 0;
      run(3);
      chk("pre_rst_req", 32'(imem_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_req", 32'(imem_req), 32'd0);
      chk("arst_addr", imem_addr, RST_PC);
      chk("arst_valid", 32'(id_valid), 32'd0);
      chk("arst_instr", id_instr, 32'd0);
      chk("arst_pc", id_pc, 32'd0);
      chk("arst_pc4", id_pc4, 32'd0);
      run(2);
      rst = 1'b0;
      ack_pct = 100; rdy_pct = 100;
      run(10);

      ack_pct = 0;
      run(8);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      chk("drain_valid", 32'(id_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
